mac_result_collector: RTL
=========================

# mac_result_collector

Receiving end of the MAC engine's result handshake. It asserts `s_ready` toward the engine and captures the 20-bit accumulated `sum` on each `s_valid && s_ready` transfer. Each captured result is requantized to an 8-bit activation (shift, optional ReLU, saturate) and buffered in a small FIFO. The FIFO drains through a downstream valid/ready port that feeds the next layer's activation buffer.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `SUM_W`, 20: width of the engine `sum`.
- `OUT_W`, 8: requantized result width.

- `clk`  in  1  clock; all state updates on rising edge.
- `nrst`  in  1  reset nrst, synchronous, active-low; clock clk.
- `s_valid`  in  1  result valid from engine (engine `valid`).
- `s_sum`  in  SUM_W  engine `sum`; sampled only on transfer.
- `s_ready`  out  1  collector can accept; drives engine `ready`.
- `signed_mode`  in  1  1 = treat `s_sum` as two's complement.
- `shift`  in  5  right-shift amount; values ≥ SUM_W are treated as SUM_W-1.
- `relu_en`  in  1  1 = clamp negative results to 0 (signed mode only).
- `m_valid`  out  1  FIFO head valid.
- `m_data`  out  OUT_W  FIFO head data.
- `m_ready`  in  1  downstream accepts head.
- `result_cnt`  out  16  accepted-result counter; wraps at 0xFFFF→0.
- `proto_err`  out  1  sticky: `s_valid` dropped without a transfer.

## Operation
- Transfer in: `s_valid && s_ready` at a rising edge. `s_ready = (count != DEPTH)`, derived only from registered state, with no combinational path from `s_valid`.
- Config (`signed_mode`, `shift`, `relu_en`) is sampled in the transfer cycle. The requantized value is computed combinationally and written to the tail entry.
- Requant, signed mode: arithmetic shift right (floor), then ReLU if `relu_en`, then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Requant, unsigned mode: logical shift right, then saturate to [0, 2^OUT_W-1]. `relu_en` is ignored.
- FIFO: circular buffer with wr_ptr, rd_ptr and count (0..DEPTH). Pointers wrap modulo DEPTH.
- Transfer out: `m_valid && m_ready`. `m_valid = (count != 0)`, and `m_data = mem[rd_ptr]`, first-word fall-through.
- Push and pop in the same cycle (count neither 0 nor DEPTH): both pointers advance and count is unchanged.
- Full: `s_ready` = 0. The engine holds `valid` and its sum until a slot frees. A pop while full raises `s_ready` on the next cycle. No push occurs in the full cycle.
- Empty: `m_valid` = 0 and `m_ready` is ignored. `m_data` shows stale `mem[rd_ptr]`; downstream must not use it.
- `result_cnt` increments on every input transfer.
- `proto_err`: set when `s_valid` was 1 and not transferred in cycle N-1, and `s_valid` = 0 in cycle N. It stays set until reset.

## Timing
- Reset (nrst = 0 at an edge) clears count, pointers, `result_cnt` and `proto_err`. FIFO memory is not cleared.
- After reset: `s_ready` = 1, `m_valid` = 0, `result_cnt` = 0, `proto_err` = 0.
- Reset mid-operation discards all buffered results. A transfer in the reset cycle is ignored.
- Latency: a result captured at edge E sets `m_valid` = 1 in the cycle after E, when the FIFO was empty.
- Engine interplay: the engine drops `valid` one cycle after the transfer edge. The collector never double-captures, because `valid` is registered in the engine and the transfer is counted at the edge.
- Throughput: one push and one pop per cycle.

## Test plan
- Basic path: reset; `signed_mode`=0, `shift`=4; one transfer of `s_sum`=0x00300 -> `m_data`=0x30 and `m_valid`=1 one cycle later. After the pop with `m_ready`=1, `m_valid`=0 and `result_cnt`=1.
- Signed and ReLU: `signed_mode`=1, `shift`=1, `s_sum`=0xFFF00 (-256) -> `m_data`=0x80. Repeat with `relu_en`=1 -> 0x00.
- Saturation:
  - unsigned, `shift`=0, `s_sum`=0x01000 -> 0xFF;
  - signed, `shift`=0, `s_sum`=0x7FFFF -> 0x7F;
  - signed, `s_sum`=0x80000 -> 0x80;
  - `shift`=31, `s_sum`=0x80000, signed -> 0xFF (-1).
- Full/backpressure: `m_ready`=0; push 4 results 1,2,3,4 -> `s_ready`=0 after the 4th. A 5th result (value 5) is held for 3 cycles with no capture. Pulse `m_ready` one cycle -> 1 popped, `s_ready`=1 next cycle, 5 captured. Drain order is 2,3,4,5.
- Simultaneous push/pop with count=2 -> count stays 2, order preserved. Pointers wrap after 6 consecutive pushes and pops.
- Error/reset:
  - `s_valid`=1 for 2 cycles while full, then 0 -> `proto_err`=1, held across later traffic.
  - Assert nrst with 3 entries buffered -> `m_valid`=0, `s_ready`=1, `result_cnt`=0 and `proto_err`=0 the cycle after reset.

Source files
------------

// File: rtl/mac_result_collector.sv
// mac_result_collector
// Receives accumulated sums from the MAC engine over a valid/ready handshake,
// requantizes each to an OUT_W-bit activation (shift, optional ReLU, saturate)
// and buffers the results in a first-word-fall-through FIFO that drains to the
// next layer through a second valid/ready port.
//
// Ports:
//   clk          clock, all state on rising edge
//   nrst         synchronous active-low reset
//   s_valid      engine result valid
//   s_sum        engine accumulated sum (SUM_W bits)
//   s_ready      collector can accept (registered-state only)
//   signed_mode  1 = s_sum is two's complement
//   shift        right-shift amount, clamped to SUM_W-1
//   relu_en      clamp negatives to 0 (signed mode only)
//   m_valid      FIFO head valid
//   m_data       FIFO head data (stale when m_valid = 0)
//   m_ready      downstream accepts head
//   result_cnt   count of accepted results, wraps
//   proto_err    sticky: s_valid dropped without a transfer
module mac_result_collector #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SUM_W = 20,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             s_valid,
  input  logic [SUM_W-1:0] s_sum,
  output logic             s_ready,
  input  logic             signed_mode,
  input  logic [4:0]       shift,
  input  logic             relu_en,
  output logic             m_valid,
  output logic [OUT_W-1:0] m_data,
  input  logic             m_ready,
  output logic [15:0]      result_cnt,
  output logic             proto_err
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [PW:0] CountFull = (PW+1)'(DEPTH);

  // Saturation bounds expressed at SUM_W so comparisons need no extension.
  localparam logic signed [SUM_W-1:0] SMax =
      {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SMin =
      {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [SUM_W-1:0] UMax = {{(SUM_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [OUT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic [15:0]      result_cnt_q;
  logic             proto_err_q;
  // Engine had valid up without a transfer in the previous cycle.
  logic             pend_q;

  logic push, pop;

  assign s_ready    = (count_q != CountFull);
  assign m_valid    = (count_q != '0);
  assign m_data     = mem[rd_ptr_q];
  assign result_cnt = result_cnt_q;
  assign proto_err  = proto_err_q;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  // Requantization
  logic [4:0]              shift_eff;
  logic signed [SUM_W-1:0] sh_s;
  logic [SUM_W-1:0]        sh_u;
  logic signed [SUM_W-1:0] relu_v;
  logic [OUT_W-1:0]        quant;

  always_comb begin
    shift_eff = (int'(shift) >= int'(SUM_W)) ? 5'(SUM_W-1) : shift;
    sh_s      = $signed(s_sum) >>> shift_eff;
    sh_u      = s_sum >> shift_eff;
    relu_v    = (relu_en && sh_s[SUM_W-1]) ? '0 : sh_s;
    quant     = '0;
    if (signed_mode) begin
      if (relu_v > SMax) begin
        quant = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (relu_v < SMin) begin
        quant = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        quant = relu_v[OUT_W-1:0];
      end
    end else begin
      if (sh_u > UMax) begin
        quant = '1;
      end else begin
        quant = sh_u[OUT_W-1:0];
      end
    end
  end

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (nrst && push) begin
      mem[wr_ptr_q] <= quant;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      result_cnt_q <= '0;
      proto_err_q  <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q     <= wr_ptr_q + 1'b1;
        result_cnt_q <= result_cnt_q + 16'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      pend_q <= s_valid && !s_ready;
      if (pend_q && !s_valid) begin
        proto_err_q <= 1'b1;
      end
    end
  end

endmodule
